// File: rtl/arb4way16.sv
// ============================================================================
//  Module   : arb4way16
//  Brief    : Four-way round-robin arbiter onto one 16-bit valid/ready channel,
//             with a per-grant burst limit. Optional macro ARB4_LOCK_EN adds a
//             lock input that lets the owner run past the burst limit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module arb4way16 #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
`ifdef ARB4_LOCK_EN
    input  logic        lock,
`endif
    input  logic        out_ready,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic [15:0] out,
    output logic        out_valid
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             w_owner_req;
    logic             w_valid;
    logic             w_xfer;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_limit;
    logic             w_burst_done;
    logic             w_release;
    logic [1:0]       w_ptr;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_any;

    always_comb begin
        w_owner_req = req[sel_q];
        w_valid     = (state_q == ST_GRANT) && w_owner_req;
        w_xfer      = w_valid && out_ready;
        w_cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        w_limit     = (w_cnt_inc >= MAX_EXT);
`ifdef ARB4_LOCK_EN
        w_burst_done = w_xfer && w_limit && !lock;
`else
        w_burst_done = w_xfer && w_limit;
`endif
        w_release   = (state_q == ST_GRANT) && (!w_owner_req || w_burst_done);
    end

    // Search begins just after the pointer; the pointer itself is checked last,
    // so a releasing owner only wins again if nobody else is asking.
    always_comb begin
        w_ptr = (state_q == ST_GRANT) ? sel_q : last_q;
        w_any = |req;
        w_win = w_ptr;
        w_idx = w_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_idx = w_ptr + 2'(k);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d = ST_GRANT;
                    sel_d   = w_win;
                    grant_d = 4'b0001 << w_win;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (w_any) begin
                        sel_d   = w_win;
                        grant_d = 4'b0001 << w_win;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (w_xfer) begin
                    // Saturation only matters while locked past the limit.
                    cnt_d = w_limit ? MAX_CNT : w_cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out = 16'h0000;
        if (w_valid) begin
            case (sel_q)
                2'd0:    out = a;
                2'd1:    out = b;
                2'd2:    out = c;
                default: out = d;
            endcase
        end
        out_valid = w_valid;
        ack       = w_xfer ? (4'b0001 << sel_q) : 4'b0000;
        grant     = grant_q;
        sel       = sel_q;
    end

endmodule

`default_nettype wire
